// File: rtl/simple_axi_burst_master.sv
// AXI4 INCR burst master: 1..MAX_BURST beats, streamed write/read beats, sticky done/error/invalid.
// Optional macro SAXI_WSTRB_EN adds a per-beat i_wstrb port; otherwise o_axi_wstrb is all ones.
module simple_axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [LEN_W-1:0]        i_len,
  input  logic [1:0]              i_rw,
  output logic                    o_wait,
  output logic                    o_done,
  input  logic                    i_clear_done,
  output logic                    o_error,
  output logic                    o_invalid,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
`ifdef SAXI_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
`endif
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic                    o_axi_awvalid,
  input  logic                    i_axi_awready,
  output logic [ADDR_WIDTH-1:0]   o_axi_awaddr,
  output logic [7:0]              o_axi_awlen,
  output logic [2:0]              o_axi_awsize,
  output logic [1:0]              o_axi_awburst,
  output logic [3:0]              o_axi_awcache,
  output logic [2:0]              o_axi_awprot,
  output logic                    o_axi_awlock,
  output logic [3:0]              o_axi_awqos,
  output logic                    o_axi_wvalid,
  input  logic                    i_axi_wready,
  output logic [DATA_WIDTH-1:0]   o_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] o_axi_wstrb,
  output logic                    o_axi_wlast,
  input  logic                    i_axi_bvalid,
  output logic                    o_axi_bready,
  input  logic [1:0]              i_axi_bresp,
  output logic                    o_axi_arvalid,
  input  logic                    i_axi_arready,
  output logic [ADDR_WIDTH-1:0]   o_axi_araddr,
  output logic [7:0]              o_axi_arlen,
  output logic [2:0]              o_axi_arsize,
  output logic [1:0]              o_axi_arburst,
  output logic [3:0]              o_axi_arcache,
  output logic [2:0]              o_axi_arprot,
  output logic                    o_axi_arlock,
  output logic [3:0]              o_axi_arqos,
  input  logic                    i_axi_rvalid,
  output logic                    o_axi_rready,
  input  logic [DATA_WIDTH-1:0]   i_axi_rdata,
  input  logic [1:0]              i_axi_rresp,
  input  logic                    i_axi_rlast
);

  localparam int         BYTES  = DATA_WIDTH / 8;
  localparam logic [2:0] AXSIZE = 3'($clog2(BYTES));

  typedef enum logic [2:0] {
    S_IDLE, S_W_ADDR, S_W_DATA, S_W_RESP, S_R_ADDR, S_R_DATA
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt_q;
  logic                  cmd_wr, cmd_rd, accept, reject, last_beat;
  logic                  w_hs, b_hs, r_hs, r_end;
  logic                  set_done, set_err, set_inv, clr_flags;
  logic [31:0]           span;

  assign cmd_wr = (i_rw == 2'b01);
  assign cmd_rd = (i_rw == 2'b10);
  assign accept = (state_q == S_IDLE) && (cmd_wr || cmd_rd);

  // Bytes touched measured from the 4 KB page offset; above 4096 the burst leaves the page.
  assign span   = 32'(i_addr[11:0]) + (32'(i_len) + 32'd1) * 32'(BYTES);
  assign reject = (32'(i_len) > 32'(MAX_BURST - 1)) || (span > 32'd4096);

  assign last_beat = (cnt_q == len_q);
  assign w_hs      = (state_q == S_W_DATA) && i_wvalid && i_axi_wready;
  assign b_hs      = (state_q == S_W_RESP) && i_axi_bvalid;
  assign r_hs      = (state_q == S_R_DATA) && i_axi_rvalid && i_rready;
  assign r_end     = r_hs && (i_axi_rlast || last_beat);

  assign o_wait = accept || ((state_q != S_IDLE) && !b_hs && !r_end);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    o_axi_awvalid = 1'b0;
    o_axi_arvalid = 1'b0;
    o_axi_wvalid  = 1'b0;
    o_axi_wlast   = 1'b0;
    o_wready      = 1'b0;
    o_axi_bready  = 1'b0;
    o_rvalid      = 1'b0;
    o_axi_rready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !reject) state_d = cmd_wr ? S_W_ADDR : S_R_ADDR;
      end
      S_W_ADDR: begin
        o_axi_awvalid = 1'b1;
        if (i_axi_awready) state_d = S_W_DATA;
      end
      S_W_DATA: begin
        o_axi_wvalid = i_wvalid;
        o_wready     = i_axi_wready;
        o_axi_wlast  = last_beat;
        if (w_hs && last_beat) state_d = S_W_RESP;
      end
      S_W_RESP: begin
        o_axi_bready = 1'b1;
        if (i_axi_bvalid) state_d = S_IDLE;
      end
      S_R_ADDR: begin
        o_axi_arvalid = 1'b1;
        if (i_axi_arready) state_d = S_R_DATA;
      end
      S_R_DATA: begin
        o_rvalid     = i_axi_rvalid;
        o_axi_rready = i_rready;
        if (r_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command fields are held for the whole burst; they need no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_q <= i_addr;
      len_q  <= i_len;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)               cnt_q <= '0;
    else if (accept)         cnt_q <= '0;
    else if (w_hs || r_hs)   cnt_q <= cnt_q + 1'b1;
  end

  assign set_done  = (accept && reject) || b_hs || r_end;
  assign set_err   = (accept && reject)
                   || (b_hs && (i_axi_bresp != 2'b00))
                   || (r_hs && ((i_axi_rresp != 2'b00) || (i_axi_rlast != last_beat)));
  assign set_inv   = (accept && reject)
                   || (b_hs && (i_axi_bresp == 2'b11))
                   || (r_hs && (i_axi_rresp == 2'b11));
  assign clr_flags = accept || i_clear_done;

  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_done    <= 1'b0;
      o_error   <= 1'b0;
      o_invalid <= 1'b0;
    end else begin
      if (set_done)       o_done <= 1'b1;
      else if (clr_flags) o_done <= 1'b0;
      if (set_err)        o_error <= 1'b1;
      else if (clr_flags) o_error <= 1'b0;
      if (set_inv)        o_invalid <= 1'b1;
      else if (clr_flags) o_invalid <= 1'b0;
    end
  end

  assign o_axi_awaddr  = addr_q;
  assign o_axi_awlen   = 8'(len_q);
  assign o_axi_awsize  = AXSIZE;
  assign o_axi_awburst = 2'b01;
  assign o_axi_awcache = 4'b0011;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_awlock  = 1'b0;
  assign o_axi_awqos   = 4'b0000;

  assign o_axi_araddr  = addr_q;
  assign o_axi_arlen   = 8'(len_q);
  assign o_axi_arsize  = AXSIZE;
  assign o_axi_arburst = 2'b01;
  assign o_axi_arcache = 4'b0011;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_arlock  = 1'b0;
  assign o_axi_arqos   = 4'b0000;

  assign o_axi_wdata = i_wdata;
  assign o_rdata     = i_axi_rdata;

`ifdef SAXI_WSTRB_EN
  assign o_axi_wstrb = (state_q == S_W_DATA) ? i_wstrb : '0;
`else
  assign o_axi_wstrb = '1;
`endif

endmodule

// File: tb/tb_simple_axi_burst_master.sv
// Randomized bench for simple_axi_burst_master: a procedural AXI slave plus a burst-level reference model.
module tb_simple_axi_burst_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 16;
  localparam int LW = 4;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic          i_rst;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_len;
  logic [1:0]    i_rw;
  logic          o_wait, o_done, i_clear_done, o_error, o_invalid;
  logic [DW-1:0] i_wdata;
  logic          i_wvalid, o_wready;
  logic [DW-1:0] o_rdata;
  logic          o_rvalid, i_rready;
  logic          o_axi_awvalid, i_axi_awready, o_axi_awlock;
  logic [AW-1:0] o_axi_awaddr;
  logic [7:0]    o_axi_awlen;
  logic [2:0]    o_axi_awsize, o_axi_awprot;
  logic [1:0]    o_axi_awburst;
  logic [3:0]    o_axi_awcache, o_axi_awqos;
  logic          o_axi_wvalid, i_axi_wready, o_axi_wlast;
  logic [DW-1:0] o_axi_wdata;
  logic [3:0]    o_axi_wstrb;
  logic          i_axi_bvalid, o_axi_bready;
  logic [1:0]    i_axi_bresp;
  logic          o_axi_arvalid, i_axi_arready, o_axi_arlock;
  logic [AW-1:0] o_axi_araddr;
  logic [7:0]    o_axi_arlen;
  logic [2:0]    o_axi_arsize, o_axi_arprot;
  logic [1:0]    o_axi_arburst;
  logic [3:0]    o_axi_arcache, o_axi_arqos;
  logic          i_axi_rvalid, o_axi_rready, i_axi_rlast;
  logic [DW-1:0] i_axi_rdata;
  logic [1:0]    i_axi_rresp;
`ifdef SAXI_WSTRB_EN
  logic [3:0]    i_wstrb = 4'hF;
`endif

  simple_axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_len(i_len), .i_rw(i_rw),
    .o_wait(o_wait), .o_done(o_done), .i_clear_done(i_clear_done),
    .o_error(o_error), .o_invalid(o_invalid),
    .i_wdata(i_wdata),
`ifdef SAXI_WSTRB_EN
    .i_wstrb(i_wstrb),
`endif
    .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .i_rready(i_rready),
    .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready), .o_axi_awaddr(o_axi_awaddr),
    .o_axi_awlen(o_axi_awlen), .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst),
    .o_axi_awcache(o_axi_awcache), .o_axi_awprot(o_axi_awprot), .o_axi_awlock(o_axi_awlock),
    .o_axi_awqos(o_axi_awqos),
    .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready), .o_axi_wdata(o_axi_wdata),
    .o_axi_wstrb(o_axi_wstrb), .o_axi_wlast(o_axi_wlast),
    .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready), .i_axi_bresp(i_axi_bresp),
    .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready), .o_axi_araddr(o_axi_araddr),
    .o_axi_arlen(o_axi_arlen), .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst),
    .o_axi_arcache(o_axi_arcache), .o_axi_arprot(o_axi_arprot), .o_axi_arlock(o_axi_arlock),
    .o_axi_arqos(o_axi_arqos),
    .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready), .i_axi_rdata(i_axi_rdata),
    .i_axi_rresp(i_axi_rresp), .i_axi_rlast(i_axi_rlast)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_rw = 2'b00; i_clear_done = 1'b0; i_wvalid = 1'b0; i_wdata = '0; i_rready = 1'b0;
    i_axi_awready = 1'b0; i_axi_wready = 1'b0; i_axi_bvalid = 1'b0; i_axi_bresp = 2'b00;
    i_axi_arready = 1'b0; i_axi_rvalid = 1'b0; i_axi_rdata = '0; i_axi_rresp = 2'b00;
    i_axi_rlast = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge i_clk); idle_inputs(); i_rst = 1'b1;
    @(negedge i_clk); i_rst = 1'b0;
  endtask

  // Presents a command for one cycle; a locally illegal burst is fully checked here.
  task automatic issue(input logic [1:0] rw, input logic [31:0] addr, input int len, output bit rej);
    int span;
    span = int'(addr[11:0]) + (len + 1) * (DW / 8);
    rej  = (len > MB - 1) || (span > 4096);
    @(negedge i_clk); idle_inputs(); i_rw = rw; i_addr = addr; i_len = LW'(len);
    #1;
    check("acc_wait", o_wait, 1);
    if (rej) begin
      check("rej_no_addr_valid", {o_axi_awvalid, o_axi_arvalid}, 2'b00);
      @(negedge i_clk); idle_inputs(); #1;
      check("rej_flags", {o_done, o_error, o_invalid, o_axi_awvalid, o_axi_arvalid}, 5'b11100);
    end
  endtask

  task automatic run_write(input logic [31:0] addr, input int len, input int aw_delay,
                           input logic [1:0] bresp, input bit clr_at_end, input int rst_at_beat);
    logic [31:0] wq[$];
    bit rej, aw_ok, fin;
    int beat, aw_wait, cyc;
    aw_ok = 0; fin = 0; beat = 0; aw_wait = 0; cyc = 0;
    for (int i = 0; i <= len; i++) wq.push_back($urandom);
    issue(2'b01, addr, len, rej);
    if (rej) return;
    while (!fin && cyc < 300) begin
      @(negedge i_clk); idle_inputs(); cyc++;
      i_axi_awready = (aw_wait >= aw_delay);
      i_axi_wready  = 1'($urandom_range(0, 1));
      if (beat <= len) begin
        i_wvalid = 1'($urandom_range(0, 1));
        i_wdata  = wq[beat];
      end
      i_axi_bvalid = (beat > len) && ($urandom_range(0, 1) == 1);
      i_axi_bresp  = bresp;
      i_clear_done = clr_at_end && i_axi_bvalid;
      #1;
      if (o_axi_awvalid) begin
        if (i_axi_awready) begin
          check("w_awaddr", o_axi_awaddr, addr);
          check("w_awlen", o_axi_awlen, len);
          check("w_aw_const", {o_axi_awsize, o_axi_awburst, o_axi_awcache, o_axi_awprot,
                               o_axi_awlock, o_axi_awqos}, {3'd2, 2'd1, 4'd3, 3'd0, 1'b0, 4'd0});
          aw_ok = 1;
        end else aw_wait++;
      end
      if (i_wvalid && o_wready) begin
        check("w_axi_wvalid", o_axi_wvalid, 1);
        check("w_data", o_axi_wdata, wq[beat]);
        check("w_last", o_axi_wlast, beat == len);
        check("w_strb", o_axi_wstrb, 4'hF);
        beat++;
        if (beat == rst_at_beat) begin
          @(negedge i_clk); idle_inputs(); i_rst = 1'b1;
          @(negedge i_clk); i_rst = 1'b0;
          i_wvalid = 1'b1; i_axi_wready = 1'b1; i_axi_rvalid = 1'b1; i_rready = 1'b1;
          #1;
          check("rst_valids", {o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid,
                               o_axi_rready, o_wready, o_rvalid, o_wait}, 8'h00);
          check("rst_flags", {o_done, o_error, o_invalid}, 3'b000);
          return;
        end
      end
      if (o_axi_bready && i_axi_bvalid) begin
        check("w_wait_end", o_wait, 0);
        fin = 1;
      end
    end
    check("w_finished", fin, 1);
    check("w_aw_seen", aw_ok, 1);
    check("w_beats", beat, len + 1);
    @(negedge i_clk); idle_inputs(); #1;
    check("w_flags", {o_done, o_error, o_invalid, o_wait},
          {1'b1, bresp != 2'b00, bresp == 2'b11, 1'b0});
    if (!fin) pulse_reset();
  endtask

  task automatic run_read(input logic [31:0] addr, input int len, input logic [1:0] rresp,
                          input int rlast_beat, input int stall_a, input int stall_b);
    logic [31:0] rq[$];
    bit rej, ar_ok, fin, last;
    int cb, ar_wait, ar_delay, held, cyc, nb;
    ar_ok = 0; fin = 0; cb = 0; ar_wait = 0; held = 0; cyc = 0;
    ar_delay = $urandom_range(0, 2);
    // The burst stops at whichever comes first: slave RLAST or the requested length.
    nb = ((rlast_beat < len) ? rlast_beat : len) + 1;
    for (int i = 0; i <= len + 1; i++) rq.push_back($urandom);
    issue(2'b10, addr, len, rej);
    if (rej) return;
    while (!fin && cyc < 400) begin
      @(negedge i_clk); idle_inputs(); cyc++;
      i_axi_arready = (ar_wait >= ar_delay);
      if (ar_ok) begin
        i_axi_rvalid = ($urandom_range(0, 3) != 0);
        i_axi_rdata  = rq[cb];
        i_axi_rresp  = rresp;
        i_axi_rlast  = (cb == rlast_beat);
      end
      if ((cb == stall_a || cb == stall_b) && held < 3) begin
        i_rready = 1'b0;
        held++;
      end else i_rready = ($urandom_range(0, 3) != 0);
      #1;
      if (o_axi_arvalid) begin
        if (i_axi_arready) begin
          check("r_araddr", o_axi_araddr, addr);
          check("r_arlen", o_axi_arlen, len);
          check("r_ar_const", {o_axi_arsize, o_axi_arburst, o_axi_arcache, o_axi_arprot,
                               o_axi_arlock, o_axi_arqos}, {3'd2, 2'd1, 4'd3, 3'd0, 1'b0, 4'd0});
          ar_ok = 1;
        end else ar_wait++;
      end
      if (o_rvalid && i_rready) begin
        last = i_axi_rlast || (cb == len);
        check("r_axi_rready", o_axi_rready, 1);
        check("r_data", o_rdata, rq[cb]);
        check("r_wait", o_wait, !last);
        cb++;
        held = 0;
        if (last) fin = 1;
      end
    end
    check("r_finished", fin, 1);
    check("r_beats", cb, nb);
    @(negedge i_clk); idle_inputs(); #1;
    check("r_flags", {o_done, o_error, o_invalid, o_wait},
          {1'b1, (rresp != 2'b00) || (rlast_beat != len), rresp == 2'b11, 1'b0});
    if (!fin) pulse_reset();
  endtask

  logic [31:0] a;
  int          l;
  logic [1:0]  resp;

  initial begin
    idle_inputs();
    i_addr = '0; i_len = '0; i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_state", {o_wait, o_done, o_error, o_invalid, o_axi_awvalid, o_axi_arvalid,
                        o_axi_bready, o_axi_rready}, 8'h00);

    run_write(32'h0000_0100, 3, 2, 2'b00, 1'b0, -1);
    run_read(32'h0000_2000, 7, 2'b00, 7, 1, 4);

    // DECERR on a single-beat read: flags stay until cleared
    run_read(32'h0000_3000, 0, 2'b11, 0, -1, -1);
    repeat (3) begin
      @(negedge i_clk); idle_inputs(); #1;
      check("decerr_hold", {o_done, o_error, o_invalid}, 3'b111);
    end
    @(negedge i_clk); idle_inputs(); i_clear_done = 1'b1;
    @(negedge i_clk); idle_inputs(); #1;
    check("decerr_cleared", {o_done, o_error, o_invalid}, 3'b000);

    run_write(32'h0000_0FF8, 3, 0, 2'b00, 1'b0, -1);
    run_read(32'h0000_0400, 3, 2'b00, 1, -1, -1);
    run_write(32'h0000_0500, 5, 0, 2'b00, 1'b0, 2);
    run_write(32'h0000_0600, 3, 1, 2'b00, 1'b0, -1);
    run_write(32'h0000_0700, 2, 1, 2'b10, 1'b1, -1);

    for (int t = 0; t < 40; t++) begin
      a = $urandom & 32'hFFFF_F000;
      if ($urandom_range(0, 1) == 1) a = a | (32'($urandom_range(0, 1023)) << 2);
      else                           a = a | (32'h1000 - (32'($urandom_range(1, 24)) << 2));
      l    = $urandom_range(0, MB - 1);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 1) == 1)
        run_write(a, l, $urandom_range(0, 3), resp, 1'($urandom_range(0, 1)), -1);
      else
        run_read(a, l, resp, ($urandom_range(0, 4) == 0) ? $urandom_range(0, l + 1) : l,
                 $urandom_range(0, l), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
